// File: rtl/alsu_result_collector.sv
// Tracks ALSU operations through its 2-stage pipeline, classifies each result, and queues tagged records.
// Latency: a record is captured 2 edges after issue and is visible on res_valid 1 cycle after capture.
// Backpressure: the FIFO holds DEPTH records; a capture into a full FIFO with no pop is dropped and sets overflow.
module alsu_result_collector #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid,
  input  logic [TAG_W-1:0]        issue_tag,
  input  logic signed [5:0]       alsu_out,
  input  logic [15:0]             alsu_leds,
  input  logic                    res_ready,
  input  logic                    clear_stats,
  output logic                    res_valid,
  output logic [TAG_W+7:0]        res_data,
  output logic                    fifo_full,
  output logic                    overflow,
  output logic [CNT_W-1:0]        op_count,
  output logic [CNT_W-1:0]        inv_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int REC_W = TAG_W + 8;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  // Delay line mirroring the ALSU's registered input and registered output stages.
  logic             s1_vld;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_vld;
  logic [TAG_W-1:0] s2_tag;

  logic [15:0]      leds_prev;

  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;

  logic             capture;
  logic             cap_inv;
  logic             cap_amb;
  logic [REC_W-1:0] cap_rec;
  logic             pop;
  logic             push;
  logic             drop;

  // An operation issued at edge E has its ALSU result on the pins during the cycle before edge E+2.
  assign capture = s2_vld;

  // The ALSU clears leds on a valid op but toggles FFFF->0 on a repeated invalid op,
  // so a 0 following FFFF cannot be told apart and is flagged ambiguous.
  assign cap_inv = (alsu_leds == 16'hFFFF);
  assign cap_amb = (alsu_leds == 16'h0000) && (leds_prev == 16'hFFFF);
  assign cap_rec = {s2_tag, cap_inv, cap_amb, alsu_out};

  assign res_valid = (occ != '0);
  assign fifo_full = (occ == OCC_FULL);
  assign pop       = res_valid && res_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push      = capture && (!fifo_full || pop);
  assign drop      = capture && fifo_full && !pop;
  assign res_data  = res_valid ? mem[rd_ptr] : '0;

  // Advance issue information through the two pipeline stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_tag <= '0;
      s2_vld <= 1'b0;
      s2_tag <= '0;
    end else begin
      s1_vld <= issue_valid;
      s1_tag <= issue_tag;
      s2_vld <= s1_vld;
      s2_tag <= s1_tag;
    end
  end

  // Remember last cycle's leds for ambiguity detection, regardless of issue activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      leds_prev <= '0;
    end else begin
      leds_prev <= alsu_leds;
    end
  end

  // Record storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= cap_rec;
    end
  end

  // Circular-buffer pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Saturating statistics and sticky overflow; clear_stats wins over any same-edge update.
  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      op_count  <= '0;
      inv_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (capture && (op_count != '1)) begin
        op_count <= op_count + 1'b1;
      end
      if (capture && cap_inv && (inv_count != '1)) begin
        inv_count <= inv_count + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alsu_result_collector.sv
// Directed bench for alsu_result_collector with a queue-based scoreboard.
// Stimulus pushes hand-computed records; a negedge monitor pops and compares on every handshake.
// A second instance with CNT_W=2 shares all inputs to exercise counter saturation.
module tb_alsu_result_collector;

  logic              clk;
  logic              rst;
  logic              issue_valid;
  logic [3:0]        issue_tag;
  logic signed [5:0] alsu_out;
  logic [15:0]       alsu_leds;
  logic              res_ready;
  logic              clear_stats;
  logic              res_valid;
  logic [11:0]       res_data;
  logic              fifo_full;
  logic              overflow;
  logic [7:0]        op_count;
  logic [7:0]        inv_count;

  logic              d2_res_valid;
  logic [11:0]       d2_res_data;
  logic              d2_fifo_full;
  logic              d2_overflow;
  logic [1:0]        d2_op_count;
  logic [1:0]        d2_inv_count;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];

  alsu_result_collector #(.TAG_W(4), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_tag(issue_tag),
    .alsu_out(alsu_out), .alsu_leds(alsu_leds), .res_ready(res_ready),
    .clear_stats(clear_stats), .res_valid(res_valid), .res_data(res_data),
    .fifo_full(fifo_full), .overflow(overflow), .op_count(op_count),
    .inv_count(inv_count)
  );

  alsu_result_collector #(.TAG_W(4), .DEPTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_tag(issue_tag),
    .alsu_out(alsu_out), .alsu_leds(alsu_leds), .res_ready(res_ready),
    .clear_stats(clear_stats), .res_valid(d2_res_valid), .res_data(d2_res_data),
    .fifo_full(d2_fifo_full), .overflow(d2_overflow), .op_count(d2_op_count),
    .inv_count(d2_inv_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] rec(input logic [3:0] t, input logic i, input logic a,
                                      input logic [5:0] o);
    return {t, i, a, o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, take the edge, settle 1 time unit past it.
  task automatic cyc(input logic rdy, input logic iv, input logic [3:0] tag,
                     input logic [5:0] o, input logic [15:0] l);
    res_ready   = rdy;
    issue_valid = iv;
    issue_tag   = tag;
    alsu_out    = o;
    alsu_leds   = l;
    @(posedge clk);
    #1;
  endtask

  // n back-to-back issues plus two flush cycles; issue i's result out0+i appears two cycles later.
  task automatic batch(input int n, input logic [3:0] tag0, input logic [5:0] out0,
                       input logic rdy);
    for (int i = 0; i < n + 2; i++) begin
      cyc(rdy, (i < n), tag0 + 4'(i), (i >= 2) ? out0 + 6'(i - 2) : 6'd0, 16'h0000);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(rdy, 1'b0, 4'd0, 6'd0, 16'h0000);
  endtask

  // Scoreboard monitor: compares the head record whenever a handshake is about to occur.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record actual=%0h expected=none", res_data);
      end else begin
        chk("record", res_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_stats = 1'b0;
    idle(2, 1'b0);
    rst = 1'b0;

    chk("reset_res_valid", res_valid, 0);
    chk("reset_res_data", res_data, 0);
    chk("reset_fifo_full", fifo_full, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_op_count", op_count, 0);
    chk("reset_inv_count", inv_count, 0);

    // Single valid op: tag 3, out 5, leds 0.
    exp_q.push_back(rec(4'd3, 1'b0, 1'b0, 6'h05));
    cyc(1'b0, 1'b1, 4'd3, 6'd0, 16'h0000);
    cyc(1'b0, 1'b0, 4'd0, 6'd0, 16'h0000);
    cyc(1'b0, 1'b0, 4'd0, 6'd5, 16'h0000);
    chk("t1_res_valid", res_valid, 1);
    chk("t1_res_data", res_data, 12'h305);
    chk("t1_op_count", op_count, 1);
    idle(1, 1'b1);
    chk("t1_drained", res_valid, 0);

    // Two invalid ops: leds 0 -> FFFF -> 0 gives inv then amb.
    exp_q.push_back(rec(4'd1, 1'b1, 1'b0, 6'd0));
    exp_q.push_back(rec(4'd2, 1'b0, 1'b1, 6'd0));
    cyc(1'b1, 1'b1, 4'd1, 6'd0, 16'h0000);
    cyc(1'b1, 1'b1, 4'd2, 6'd0, 16'h0000);
    cyc(1'b1, 1'b0, 4'd0, 6'd0, 16'hFFFF);
    cyc(1'b1, 1'b0, 4'd0, 6'd0, 16'h0000);
    idle(2, 1'b1);
    chk("t2_inv_count", inv_count, 1);
    chk("t2_op_count", op_count, 3);

    // Five captures with no consumer: four held, fifth dropped.
    clear_stats = 1'b1;
    idle(1, 1'b1);
    clear_stats = 1'b0;
    for (int j = 0; j < 4; j++) exp_q.push_back(rec(4'(4 + j), 1'b0, 1'b0, 6'(10 + j)));
    batch(5, 4'd4, 6'd10, 1'b0);
    chk("t3_fifo_full", fifo_full, 1);
    chk("t3_overflow", overflow, 1);
    chk("t3_op_count", op_count, 5);
    idle(5, 1'b1);
    chk("t3_drained", res_valid, 0);

    // Full FIFO with push and pop on the same edge.
    clear_stats = 1'b1;
    idle(1, 1'b1);
    clear_stats = 1'b0;
    for (int j = 0; j < 4; j++) exp_q.push_back(rec(4'(j), 1'b0, 1'b0, 6'(20 + j)));
    exp_q.push_back(rec(4'd9, 1'b0, 1'b0, 6'd30));
    batch(4, 4'd0, 6'd20, 1'b0);
    chk("t4_full_before", fifo_full, 1);
    cyc(1'b0, 1'b1, 4'd9, 6'd0, 16'h0000);
    cyc(1'b0, 1'b0, 4'd0, 6'd0, 16'h0000);
    cyc(1'b1, 1'b0, 4'd0, 6'd30, 16'h0000);
    chk("t4_full_after_pushpop", fifo_full, 1);
    chk("t4_overflow", overflow, 0);
    idle(5, 1'b1);
    chk("t4_drained", res_valid, 0);
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 4; j++)
        exp_q.push_back(rec(4'(4 * r + 1 + j), 1'b0, 1'b0, 6'(40 + 4 * r + j)));
      batch(4, 4'(4 * r + 1), 6'(40 + 4 * r), 1'b0);
      chk("t4_wrap_full", fifo_full, 1);
      idle(4, 1'b1);
      chk("t4_wrap_empty", res_valid, 0);
    end
    chk("t4_overflow_end", overflow, 0);

    // Reset with three queued records and two ops in flight.
    batch(3, 4'd1, 6'd50, 1'b0);
    cyc(1'b0, 1'b1, 4'd5, 6'd0, 16'h0000);
    cyc(1'b0, 1'b1, 4'd6, 6'd0, 16'h0000);
    rst = 1'b1;
    exp_q.delete();
    cyc(1'b0, 1'b0, 4'd0, 6'd33, 16'h0000);
    rst = 1'b0;
    chk("t5_res_valid", res_valid, 0);
    chk("t5_res_data", res_data, 0);
    chk("t5_fifo_full", fifo_full, 0);
    chk("t5_overflow", overflow, 0);
    chk("t5_op_count", op_count, 0);
    chk("t5_inv_count", inv_count, 0);
    idle(4, 1'b1);
    chk("t5_no_records", res_valid, 0);
    chk("t5_op_count_after", op_count, 0);

    // Counter saturation on the narrow instance, then clear racing a capture and a drop.
    clear_stats = 1'b1;
    idle(1, 1'b1);
    clear_stats = 1'b0;
    for (int j = 0; j < 5; j++) exp_q.push_back(rec(4'(2 + j), 1'b0, 1'b0, 6'(1 + j)));
    batch(5, 4'd2, 6'd1, 1'b1);
    idle(2, 1'b1);
    chk("t6_sat_op_count", d2_op_count, 3);
    chk("t6_wide_op_count", op_count, 5);
    for (int j = 0; j < 4; j++) exp_q.push_back(rec(4'(8 + j), 1'b0, 1'b0, 6'(33 + j)));
    for (int i = 0; i < 7; i++) begin
      clear_stats = (i == 6);
      cyc(1'b0, (i < 5), 4'(8 + i), (i >= 2) ? 6'(33 + i - 2) : 6'd0, 16'h0000);
    end
    clear_stats = 1'b0;
    chk("t6_clear_op_count", op_count, 0);
    chk("t6_clear_overflow", overflow, 0);
    chk("t6_clear_sat_op_count", d2_op_count, 0);
    chk("t6_fifo_full", fifo_full, 1);
    idle(5, 1'b1);
    chk("t6_drained", res_valid, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alsu_result_collector.md
Name: alsu_result_collector

Overview:
Receiving end of the ALSU datapath. It tracks every operation issued to the ALSU through the ALSU's fixed 2-stage pipeline, which has registered inputs and a registered output. At the correct cycle it captures `out` and `leds`, classifies the result as valid, invalid or ambiguous, and pushes a tagged record into a small FIFO that a downstream consumer drains with a valid/ready handshake. It also keeps saturating operation and invalid-result counters.

Parameters:
- TAG_W, 4, width of the per-operation tag.
- DEPTH, 4, result FIFO depth in entries; power of two, ≥ 2.
- CNT_W, 8, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- issue_valid  in  1  ALSU inputs at this edge form a meaningful operation.
- issue_tag  in  TAG_W  tag for the issued operation.
- alsu_out  in  6  signed ALSU `out`.
- alsu_leds  in  16  ALSU `leds`.
- res_ready  in  1  consumer accepts the head record.
- clear_stats  in  1  clear the counters and the overflow flag.
- res_valid  out  1  FIFO not empty.
- res_data  out  TAG_W+8  {tag, inv, amb, out[5:0]}, MSB first.
- fifo_full  out  1  FIFO holds DEPTH entries.
- overflow  out  1  sticky; a record was dropped.
- op_count  out  CNT_W  records captured, saturating.
- inv_count  out  CNT_W  records with inv=1, saturating.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is synchronous and active-high, sampled only on the rising edge of clk.
  - Reset clears the delay line, leds_prev, the FIFO pointers and occupancy, overflow, op_count and inv_count.
  - Outputs after reset: res_valid=0, res_data=0, fifo_full=0, overflow=0, op_count=0, inv_count=0.
  - Reset asserted mid-operation discards all in-flight issues and all FIFO contents.
- Delay line (2 stages):
  - {issue_valid, issue_tag} is sampled at edge E into s1 and moves to s2 at E+1.
  - At edge E+2 with s2 valid, a capture occurs: alsu_out and alsu_leds are sampled. These are the values driven by the ALSU after its edge E+1.
  - Back-to-back issues on every cycle are supported; there are no bubbles.
- leds tracking:
  - leds_prev <= alsu_leds on every non-reset edge, independent of issue activity.
- Classification at capture (L = alsu_leds, P = leds_prev):
  - L==16'hFFFF: inv=1, amb=0.
  - L==0 and P==16'hFFFF: inv=0, amb=1. The ALSU clears leds on a valid op but toggles FFFF→0 on an invalid one, so these two cases are indistinguishable.
  - Otherwise: inv=0, amb=0.
  - Any L other than 0 or FFFF is still recorded with inv=0, amb=0. That value signals a protocol error for the bench.
- Record:
  - {s2.tag, inv, amb, alsu_out} is pushed at the capture edge.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo DEPTH; occupancy ranges 0..DEPTH.
  - res_data shows the head entry combinationally from storage, and is 0 when empty.
  - Pop happens when res_valid && res_ready at an edge.
  - Push while full with a pop on the same edge: both happen and occupancy stays DEPTH.
  - Push while full with no pop: the record is dropped and overflow is set. Counters still update.
  - Push while empty: the record appears on res_valid the next cycle. Same-cycle pass-through is not allowed.
  - res_ready while empty is ignored.
- Counters:
  - op_count increments on every capture, including dropped records.
  - inv_count increments on captures with inv=1.
  - Both counters saturate at 2^CNT_W−1.
  - clear_stats zeroes op_count, inv_count and overflow. It takes priority over an increment or overflow set on the same edge.
  - clear_stats does not touch the FIFO or the delay line.

Test Plan:
1. Reset, then issue tag=3 at edge 1 with ALSU producing out=6'sh05, leds=0 after edge 2 → record {3,0,0,05} pushed at edge 3. res_valid=1 after edge 3; op_count=1.
2. Issue tags 1,2 on consecutive edges, invalid opcode on both (leds goes 0→FFFF→0) → tag1 record inv=1, amb=0; tag2 record inv=0, amb=1; inv_count=1.
3. res_ready=0, issue 5 ops with DEPTH=4 → 4 entries held, fifo_full=1, 5th dropped, overflow=1, op_count=5. Draining returns tags in issue order.
4. FIFO full, push and pop on the same edge → occupancy stays 4 and overflow stays 0. Pointers wrap correctly across 3 full fill/drain cycles.
5. Assert rst with 2 ops in the delay line and 3 FIFO entries → no records appear afterward and all outputs are 0.
6. CNT_W=2 with 5 captures → op_count holds at 3. clear_stats coincident with a capture → op_count=0 and overflow=0.
